// File: rtl/ram_log_reader.sv
// ram_log_reader: walks the log Block RAM from address 0 after a capture
// and streams each 32-bit word out MSB byte first over a valid/ready link
// toward the UART transmitter. The read enable stays high for the whole dump
// so the logger's write address is held and rewound.
module ram_log_reader #(
   parameter int RAM_WIDTH  = 32,
   parameter int RAM_DEPTH  = 32000,
   parameter int ADRS_W     = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [ADRS_W-1:0]    i_n_words,
   output logic [ADRS_W-1:0]    o_read_adrs,
   output logic                 o_enbl_read,
   input  logic [RAM_WIDTH-1:0] i_data_for_read,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int BYTES_C = RAM_WIDTH / 8;
   localparam int IDX_W_C = (BYTES_C > 1) ? $clog2(BYTES_C) : 1;

   localparam logic [IDX_W_C-1:0] IDX_LAST_C = IDX_W_C'(BYTES_C - 1);
   localparam logic [IDX_W_C-1:0] IDX_ONE_C  = IDX_W_C'(1);
   localparam logic [1:0]         LAT_LAST_C = 2'(RD_LATENCY - 1);
   localparam logic [ADRS_W-1:0]  DEPTH_C    = ADRS_W'(RAM_DEPTH);
   localparam logic [ADRS_W-1:0]  ADRS_ONE_C = ADRS_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_SEND = 3'd2,
      ST_NEXT = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t               state_r;
   logic [ADRS_W-1:0]    adrs_r;
   logic [ADRS_W-1:0]    n_r;
   logic [1:0]           lat_r;
   logic [IDX_W_C-1:0]   idx_r;
   logic [RAM_WIDTH-1:0] word_r;
   logic [7:0]           tx_data_r;
   logic                 tx_valid_r;
   logic                 enbl_r;
   logic                 busy_r;
   logic                 done_r;
   logic [ADRS_W-1:0]    n_clamp_s;

   // Byte number i of a word, counting from the most significant byte.
   function automatic logic [7:0] sel_byte(input logic [RAM_WIDTH-1:0] w,
                                           input logic [IDX_W_C-1:0]   i);
      logic [RAM_WIDTH-1:0] sh;
      sh = w << {i, 3'b000};
      return sh[RAM_WIDTH-1 -: 8];
   endfunction

   // Requested length limited to the number of words the RAM actually holds.
   always_comb begin
      n_clamp_s = i_n_words;
      if (i_n_words > DEPTH_C) begin
         n_clamp_s = DEPTH_C;
      end else begin
         n_clamp_s = i_n_words;
      end
   end

   // Dump sequencer: request word, wait the read latency, send its bytes, advance.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_r    <= ST_IDLE;
         adrs_r     <= '0;
         n_r        <= '0;
         lat_r      <= 2'd0;
         idx_r      <= '0;
         word_r     <= '0;
         tx_data_r  <= 8'd0;
         tx_valid_r <= 1'b0;
         enbl_r     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (i_start) begin
                  n_r    <= n_clamp_s;
                  adrs_r <= '0;
                  lat_r  <= 2'd0;
                  busy_r <= 1'b1;
                  if (n_clamp_s == '0) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_REQ;
                     enbl_r  <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (lat_r == LAT_LAST_C) begin
                  word_r     <= i_data_for_read;
                  idx_r      <= '0;
                  tx_data_r  <= sel_byte(i_data_for_read, '0);
                  tx_valid_r <= 1'b1;
                  state_r    <= ST_SEND;
               end else begin
                  lat_r <= lat_r + 2'd1;
               end
            end
            ST_SEND: begin
               // Data and valid hold still until the transmitter takes the byte.
               if (i_tx_ready) begin
                  if (idx_r == IDX_LAST_C) begin
                     tx_valid_r <= 1'b0;
                     state_r    <= ST_NEXT;
                  end else begin
                     idx_r     <= idx_r + IDX_ONE_C;
                     tx_data_r <= sel_byte(word_r, idx_r + IDX_ONE_C);
                  end
               end
            end
            ST_NEXT: begin
               if (adrs_r == (n_r - ADRS_ONE_C)) begin
                  enbl_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  adrs_r  <= adrs_r + ADRS_ONE_C;
                  lat_r   <= 2'd0;
                  state_r <= ST_REQ;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r    <= ST_IDLE;
               tx_valid_r <= 1'b0;
               enbl_r     <= 1'b0;
               busy_r     <= 1'b0;
               done_r     <= 1'b0;
            end
         endcase
      end
   end

   assign o_read_adrs = adrs_r;
   assign o_enbl_read = enbl_r;
   assign o_tx_data   = tx_data_r;
   assign o_tx_valid  = tx_valid_r;
   assign o_busy      = busy_r;
   assign o_done      = done_r;

endmodule

// File: tb/tb_ram_log_reader.sv
// Bench for ram_log_reader: a small RAM model, a byte scoreboard and
// randomized dumps, with a reduced RAM depth so clamping stays short.
module tb_ram_log_reader;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic [15:0] i_n_words;
   logic [15:0] o_read_adrs;
   logic        o_enbl_read;
   logic [31:0] ram_data;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_busy;
   logic        o_done;

   logic [31:0] mem [0:DEPTH-1];
   logic [7:0]  exp_q [$];

   int   total = 0;
   int   bad = 0;
   int   got_cnt = 0;
   int   done_cnt = 0;
   int   ready_mode = 0;
   int   stall_cnt = 0;
   bit   prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;

   always #5 clk = ~clk;

   ram_log_reader #(
      .RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .ADRS_W(16), .RD_LATENCY(1)
   ) dut (
      .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_n_words(i_n_words),
      .o_read_adrs(o_read_adrs), .o_enbl_read(o_enbl_read), .i_data_for_read(ram_data),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_busy(o_busy), .o_done(o_done)
   );

   // RAM read port with one cycle of latency, counted from the presented address.
   always_comb ram_data = mem[o_read_adrs[5:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timeout", name);
   endtask

   // Reference: the dump sends words 0..min(n,DEPTH)-1, each MSB byte first.
   function automatic int push_expected(input int n);
      int nc;
      logic [31:0] w;
      nc = (n > DEPTH) ? DEPTH : n;
      for (int a = 0; a < nc; a++) begin
         w = mem[a];
         for (int k = 0; k < 4; k++) exp_q.push_back(8'((w >> (8 * (3 - k))) & 32'hff));
      end
      return nc;
   endfunction

   // Monitor: compares each transferred byte and checks holding during stalls.
   always @(negedge clk) begin
      if (i_reset) begin
         if (prev_stall) begin
            chk("hold_valid", o_tx_valid, 1);
            chk("hold_data", o_tx_data, prev_data);
         end
         if (o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_byte: got %0h expected none", o_tx_data);
            end else begin
               chk("byte", o_tx_data, exp_q.pop_front());
            end
            got_cnt++;
         end
         prev_stall = o_tx_valid && !i_tx_ready;
         prev_data  = o_tx_data;
         if (o_done) done_cnt++;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Ready driver: 0 always ready, 1 random, 2 five-cycle stall on the third byte.
   initial begin
      i_tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: i_tx_ready = ($urandom_range(0, 2) != 0);
            2: begin
               if (o_tx_valid && got_cnt == 2 && stall_cnt < 5) begin
                  i_tx_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  i_tx_ready = 1'b1;
               end
            end
            default: i_tx_ready = 1'b1;
         endcase
      end
   end

   task automatic do_dump(input int n, input int mode, input bit poke);
      int nc;
      int cyc;
      int max_a;
      int done0;
      bit adrs_ok;
      ready_mode = mode;
      stall_cnt  = 0;
      got_cnt    = 0;
      nc    = push_expected(n);
      done0 = done_cnt;
      @(posedge clk);
      #1;
      i_start   = 1'b1;
      i_n_words = 16'(n);
      @(posedge clk);
      #1;
      i_start = 1'b0;
      cyc     = 0;
      max_a   = -1;
      adrs_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (cyc == 0) begin
            chk("enbl_after_start", o_enbl_read, nc > 0);
            chk("done_after_start", o_done, nc == 0);
         end
         if (!o_busy) begin
            i_start = 1'b0;
            break;
         end
         cyc++;
         if (o_enbl_read) begin
            if (int'(o_read_adrs) > max_a) max_a = int'(o_read_adrs);
            if (nc == 0 || int'(o_read_adrs) > nc - 1) adrs_ok = 1'b0;
         end
         if (poke && !o_done && $urandom_range(0, 2) == 0) begin
            i_start   = 1'b1;
            i_n_words = 16'($urandom_range(0, 200));
         end else begin
            i_start = 1'b0;
         end
         if (cyc > 5000) begin
            timeout("dump_busy");
            break;
         end
      end
      i_start = 1'b0;
      chk("bytes_left", exp_q.size(), 0);
      chk("done_pulses", done_cnt - done0, 1);
      chk("last_adrs", max_a, nc - 1);
      chk("adrs_in_range", adrs_ok, 1);
      if (mode == 0) chk("busy_cycles", cyc, 6 * nc + 1);
      if (mode == 2) begin
         chk("stall_len", stall_cnt, 5);
         chk("busy_cycles_stall", cyc, 6 * nc + 1 + 5);
      end
      exp_q.delete();
   endtask

   initial begin
      int done0;
      int waited;
      i_reset   = 1'b0;
      i_start   = 1'b0;
      i_n_words = 16'd0;
      for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", o_tx_valid, 0);
      chk("rst_enbl", o_enbl_read, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_data", o_tx_data, 0);
      chk("rst_adrs", o_read_adrs, 0);
      @(posedge clk);
      #1;
      i_reset = 1'b1;

      mem[0] = 32'h12345678;
      do_dump(1, 0, 1'b0);

      mem[0] = 32'hA0A1A2A3;
      mem[1] = 32'hB0B1B2B3;
      mem[2] = 32'hC0C1C2C3;
      do_dump(3, 0, 1'b0);

      mem[0] = 32'h12345678;
      do_dump(1, 2, 1'b0);

      do_dump(0, 0, 1'b0);

      for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
      do_dump(40000, 0, 1'b0);

      for (int t = 0; t < 6; t++) do_dump($urandom_range(1, 10), 1, 1'b0);

      do_dump(5, 0, 1'b1);

      // Abort a dump while byte 1 of word 5 is on the stream.
      for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
      ready_mode = 0;
      got_cnt    = 0;
      done0      = push_expected(8);
      done0      = done_cnt;
      @(posedge clk);
      #1;
      i_start   = 1'b1;
      i_n_words = 16'd8;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      waited  = 0;
      while (got_cnt < 21 && waited < 500) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (waited >= 500) timeout("reach_word5");
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_valid", o_tx_valid, 0);
      chk("abort_enbl", o_enbl_read, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_done", o_done, 0);
      chk("abort_data", o_tx_data, 0);
      chk("abort_adrs", o_read_adrs, 0);
      chk("abort_no_done", done_cnt - done0, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      i_reset = 1'b1;
      mem[0] = $urandom;
      do_dump(1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_log_reader.md
Name: ram_log_reader

Overview:
- Read-side companion to the RAM logging controller. Once a capture is complete, it walks the log Block RAM from address 0 for a requested number of words.
- For each word it drives the RAM read port, latches the returned 32-bit data and serializes it MSB-byte-first into a byte stream with valid/ready handshake. The stream feeds the UART transmitter toward the host.
- It holds the RAM read enable for the whole dump, which also freezes and rewinds the logger's write address counter.

Parameters:
- RAM_WIDTH, 32, data width of RAM words; must be a multiple of 8.
- RAM_DEPTH, 32000, number of valid RAM words; upper clamp for the dump length.
- ADRS_W, 16, read address width.
- RD_LATENCY, 1, cycles from address/enable presented to valid i_data_for_read; range 1..3.

Ports:
- i_clock, in, 1, system clock.
- i_reset, in, 1, synchronous reset, active-low (0 = reset).
- i_start, in, 1, dump request; sampled only in IDLE.
- i_n_words, in, ADRS_W, number of words to dump; sampled with i_start.
- o_read_adrs, out, ADRS_W, RAM read address.
- o_enbl_read, out, 1, RAM read enable; also the logger's read/hold flag.
- i_data_for_read, in, RAM_WIDTH, RAM read data.
- o_tx_data, out, 8, byte to transmitter.
- o_tx_valid, out, 1, o_tx_data valid.
- i_tx_ready, in, 1, transmitter accepts byte.
- o_busy, out, 1, high in any state other than IDLE.
- o_done, out, 1, one-cycle pulse at end of dump.

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - state=IDLE; all outputs 0; internal word, byte and latency counters 0.
  - Reset mid-dump aborts immediately; a partially sent word is dropped and o_done is not pulsed.
- IDLE:
  - On i_start=1, latch N = min(i_n_words, RAM_DEPTH) and set address=0.
  - If N=0, go to DONE; otherwise go to REQ.
  - i_start is ignored in every other state.
- REQ:
  - o_enbl_read=1, o_read_adrs=current address.
  - Stay RD_LATENCY cycles, counted with the latency counter.
  - At the edge ending the last REQ cycle, latch i_data_for_read into the word register and go to SEND with byte index 0.
- SEND:
  - o_tx_valid=1; o_tx_data = word byte [RAM_WIDTH-1-8*idx -: 8], so MSB byte first.
  - A byte transfers only on an edge with o_tx_valid=1 and i_tx_ready=1; idx then increments.
  - o_tx_data and o_tx_valid stay stable while i_tx_ready=0; stalls of any length are allowed.
  - After the last byte (idx = RAM_WIDTH/8-1) transfers, go to NEXT. o_tx_valid drops in NEXT.
- NEXT:
  - If address = N-1, go to DONE; else address+1 and go to REQ.
  - The address never exceeds N-1 and never wraps.
- DONE:
  - o_done=1 for exactly one cycle, then IDLE.
- Output levels by state:
  - o_enbl_read=1 in REQ, SEND and NEXT.
  - o_enbl_read=0 in IDLE and DONE.
  - o_busy=1 in all states except IDLE.
- Per-word cost with i_tx_ready tied high: RD_LATENCY + RAM_WIDTH/8 + 1 cycles. With defaults this is 6 cycles.
- Simultaneous i_start and o_done: i_start is not accepted, because the FSM is in DONE, not IDLE.
- o_read_adrs holds its last value in IDLE and DONE; it is not required to be zero there.

Test Plan:
- Single word, ready high, defaults: RAM[0]=0x12345678, start with N=1.
  - o_enbl_read rises the cycle after start.
  - Bytes 0x12, 0x34, 0x56, 0x78 on 4 consecutive cycles.
  - o_done pulses once; o_busy stays high for 7 cycles.
- N=3, RAM[0..2]=0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3, ready high:
  - 12 bytes arrive in address order.
  - o_read_adrs sequence is 0, 1, 2.
  - Total busy time is 18 + 1 (DONE) cycles.
- Backpressure: N=1, i_tx_ready low for 5 cycles at byte 2:
  - o_tx_data holds 0x56 with o_tx_valid=1 throughout the stall.
  - No byte is duplicated or lost after ready returns.
- Boundaries:
  - N=0: no o_tx_valid, no o_enbl_read; o_done pulses 1 cycle after start.
  - N=40000: clamped to 32000; last o_read_adrs is 31999.
- Reset and ignored start:
  - i_reset=0 during byte 1 of word 5 gives all outputs 0 next cycle.
  - A new start with N=1 then dumps RAM[0] correctly.
  - i_start pulses while busy are ignored.
